// File: rtl/pulse_gen_pkg.sv
// Shared constants and divider state encoding for the pulse-period generator.
// Elaboration-time helpers only; no logic, no latency, no flow control.
package pulse_gen_pkg;

   localparam int OPW = 32;

   typedef enum logic [1:0] {
      DIV_IDLE,
      DIV_RUN,
      DIV_DONE
   } div_state_e;

   function automatic int step_wdth(input int steps);
      return (steps > 1) ? $clog2(steps) : 1;
   endfunction

   function automatic int step_hz(input int fmin, input int fmax, input int steps);
      return (fmax - fmin) / (steps - 1);
   endfunction

   function automatic int half0(input int clk_freq, input int fmin);
      return clk_freq / (2 * fmin);
   endfunction

   function automatic int div_wdth(input int h0);
      return $clog2(h0 + 1);
   endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider producing a DIV_WDTH-bit quotient, one bit per cycle.
// Latency: DIV_WDTH cycles busy, then a one-cycle done strobe; start ignored unless idle.
module seq_divider
   import pulse_gen_pkg::*;
#(
   parameter int DIV_WDTH = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic [OPW-1:0]      dividend_i,
   input  logic [OPW-1:0]      divisor_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [DIV_WDTH-1:0] quot_o
);

   localparam int CW = $clog2(DIV_WDTH + 1);

   div_state_e     state;
   logic [OPW-1:0] rem;
   logic [OPW-1:0] dvd_sh;
   logic [OPW-1:0] dsr;
   logic [CW-1:0]  cnt;
   logic [OPW:0]   partial;
   logic [OPW+1:0] trial;
   logic           neg;

   // Quotient fits in DIV_WDTH bits, so the bits above it seed the remainder.
   always_comb begin
      partial = {rem, dvd_sh[OPW-1]};
      trial   = {1'b0, partial} - {2'b00, dsr};
      neg     = trial[OPW+1];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state  <= DIV_IDLE;
         busy_o <= 1'b0;
         done_o <= 1'b0;
         rem    <= '0;
         dvd_sh <= '0;
         dsr    <= '0;
         cnt    <= '0;
         quot_o <= '0;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (start_i) begin
                  state  <= DIV_RUN;
                  busy_o <= 1'b1;
                  rem    <= dividend_i >> DIV_WDTH;
                  dvd_sh <= dividend_i << (OPW - DIV_WDTH);
                  dsr    <= divisor_i;
                  cnt    <= CW'(DIV_WDTH - 1);
                  quot_o <= '0;
               end
            end
            DIV_RUN: begin
               rem    <= neg ? partial[OPW-1:0] : trial[OPW-1:0];
               dvd_sh <= dvd_sh << 1;
               quot_o <= {quot_o[DIV_WDTH-2:0], ~neg};
               if (cnt == '0) begin
                  state  <= DIV_DONE;
                  busy_o <= 1'b0;
                  done_o <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DIV_DONE: begin
               state  <= DIV_IDLE;
               done_o <= 1'b0;
            end
            default: state <= DIV_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/pulse_period_ctrl.sv
// Step-indexed square-wave generator; step pulses retune the half period via seq_divider.
// Latency: new period within DIV_WDTH+1+old_half cycles; PULSE_PERIOD_CTRL_GLITCHFREE_EN applies at boundaries.
module pulse_period_ctrl
   import pulse_gen_pkg::*;
#(
   parameter int  CLK_FREQ   = 50_000_000,
   parameter int  MIN_FREQ   = 1,
   parameter int  MAX_FREQ   = 16,
   parameter int  FREQ_STEPS = 16,
   localparam int STEP_WDTH  = step_wdth(FREQ_STEPS)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 freq_up_i,
   input  logic                 freq_dwn_i,
   output logic [STEP_WDTH-1:0] step_o,
   output logic                 busy_o,
   output logic                 wave_o,
   output logic                 pulse_o
);

   localparam int STEP_HZ  = step_hz(MIN_FREQ, MAX_FREQ, FREQ_STEPS);
   localparam int HALF0    = half0(CLK_FREQ, MIN_FREQ);
   localparam int DIV_WDTH = div_wdth(HALF0);
   localparam logic [STEP_WDTH-1:0] STEP_MAX = STEP_WDTH'(FREQ_STEPS - 1);
   localparam logic [DIV_WDTH-1:0]  HALF0_V  = DIV_WDTH'(HALF0);

   logic [STEP_WDTH-1:0] step_nxt;
   logic                 step_chg;
   logic                 div_busy, div_done, div_idle, div_start;
   logic                 dirty, rerun, res_vld, pend_vld, tc;
   logic [OPW-1:0]       divisor;
   logic [DIV_WDTH-1:0]  quot, res_half, pend_half, active_half, cnt;

   always_comb begin
      step_nxt = step_o;
      if (freq_up_i && !freq_dwn_i && step_o != STEP_MAX)
         step_nxt = step_o + 1'b1;
      else if (freq_dwn_i && !freq_up_i && step_o != '0)
         step_nxt = step_o - 1'b1;
   end

   assign step_chg  = (step_nxt != step_o);
   assign div_idle  = !div_busy && !div_done;
   assign div_start = div_idle && (step_chg || rerun);
   assign divisor   = OPW'(2 * (MIN_FREQ + int'(step_nxt) * STEP_HZ));
   // A result is stale if the step moved at any point since its divide began.
   assign res_vld   = div_done && !dirty && !step_chg;
   assign res_half  = (quot == '0) ? DIV_WDTH'(1) : quot;
   assign tc        = (cnt == active_half - 1'b1);
   assign busy_o    = div_busy;

   seq_divider #(
      .DIV_WDTH(DIV_WDTH)
   ) u_div (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .start_i   (div_start),
      .dividend_i(OPW'(CLK_FREQ)),
      .divisor_i (divisor),
      .busy_o    (div_busy),
      .done_o    (div_done),
      .quot_o    (quot)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         step_o      <= '0;
         dirty       <= 1'b0;
         rerun       <= 1'b0;
         pend_vld    <= 1'b0;
         pend_half   <= HALF0_V;
         active_half <= HALF0_V;
         cnt         <= '0;
         wave_o      <= 1'b0;
         pulse_o     <= 1'b0;
      end else begin
         step_o  <= step_nxt;
         rerun   <= div_done && (dirty || step_chg);
         pulse_o <= 1'b0;
         if (div_done)
            dirty <= 1'b0;
         else if (step_chg && !div_idle)
            dirty <= 1'b1;
`ifdef PULSE_PERIOD_CTRL_GLITCHFREE_EN
         if (res_vld) begin
            pend_half <= res_half;
            pend_vld  <= 1'b1;
         end
         if (tc) begin
            cnt     <= '0;
            wave_o  <= ~wave_o;
            pulse_o <= ~wave_o;
            if (pend_vld || res_vld) begin
               active_half <= res_vld ? res_half : pend_half;
               pend_vld    <= 1'b0;
            end
         end else begin
            cnt <= cnt + 1'b1;
         end
`else
         // Forced restart: level is held, so no rising edge and no strobe.
         if (pend_vld) begin
            active_half <= pend_half;
            pend_vld    <= 1'b0;
            cnt         <= '0;
         end else if (tc) begin
            cnt     <= '0;
            wave_o  <= ~wave_o;
            pulse_o <= ~wave_o;
         end else begin
            cnt <= cnt + 1'b1;
         end
         if (res_vld) begin
            pend_half <= res_half;
            pend_vld  <= 1'b1;
         end
`endif
      end
   end

endmodule
